// File: rtl/return_addr_stack_pkg.sv
// Shared definitions for the return-address stack predictor: the Y86 icodes
// it reacts to and the per-stack operation decode.
package return_addr_stack_pkg;

  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } ras_op_e;

  // A call pushes its return address, a ret pops; everything else is inert.
  function automatic ras_op_e decode_op(input logic [3:0] icode);
    ras_op_e op;
    case (icode)
      ICALL:   op = OP_PUSH;
      IRET:    op = OP_POP;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/return_addr_stack_core.sv
// One circular return-address stack. The next-state image is exported so a
// sibling stack can be loaded with this stack's post-update contents.
module ras_stack_core #(
  parameter int DEPTH = 8,
  parameter int AW    = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     load_i,
  input  logic [AW-1:0]            push_data_i,
  input  logic [DEPTH*AW-1:0]      load_mem_i,
  input  logic [$clog2(DEPTH)-1:0] load_tp_i,
  input  logic [$clog2(DEPTH):0]   load_cnt_i,
  output logic [DEPTH*AW-1:0]      nxt_mem_o,
  output logic [$clog2(DEPTH)-1:0] nxt_tp_o,
  output logic [$clog2(DEPTH):0]   nxt_cnt_o,
  output logic [AW-1:0]            top_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] TP_ONE  = PW'(1);

  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];
  logic [PW-1:0] tp_q, tp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] top_idx_s;

  // Next-state: load overrides any op; push wraps and saturates, pop ignores underflow.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    tp_d  = tp_q;
    cnt_d = cnt_q;
    if (load_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = load_mem_i[i*AW +: AW];
      end
      tp_d  = load_tp_i;
      cnt_d = load_cnt_i;
    end else if (push_i) begin
      mem_d[tp_q] = push_data_i;
      tp_d        = tp_q + TP_ONE;
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (pop_i) begin
      if (cnt_q != '0) begin
        tp_d  = tp_q - TP_ONE;
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        tp_d  = tp_q;
        cnt_d = cnt_q;
      end
    end else begin
      tp_d  = tp_q;
      cnt_d = cnt_q;
    end
  end

  // State register; reset clears every entry so the prediction reads 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign nxt_mem_o[g*AW +: AW] = mem_d[g];
  end

  assign nxt_tp_o  = tp_d;
  assign nxt_cnt_o = cnt_d;
  assign top_idx_s = tp_q - TP_ONE;
  assign top_o     = mem_q[top_idx_s];
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack predictor: a speculative stack driven by fetch and a
// committed stack driven by write-back; a flush reloads the speculative copy
// from the committed stack's post-commit state.
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   f_fire_i,
  input  logic [3:0]             f_icode_i,
  input  logic [AW-1:0]          f_valP_i,
  input  logic                   flush_i,
  input  logic                   w_commit_i,
  input  logic [3:0]             W_icode_i,
  input  logic [AW-1:0]          W_retaddr_i,
  output logic [AW-1:0]          f_predRet_o,
  output logic                   f_predRet_valid_o,
  output logic [$clog2(DEPTH):0] spec_count_o
);

  localparam int PW = $clog2(DEPTH);

  ras_op_e f_op_s, w_op_s;
  logic spec_push_s, spec_pop_s, spec_load_s;
  logic cmt_push_s, cmt_pop_s;

  logic [DEPTH*AW-1:0] cmt_nxt_mem_s;
  logic [PW-1:0]       cmt_nxt_tp_s;
  logic [PW:0]         cmt_nxt_cnt_s;
  logic [PW:0]         spec_cnt_s;

  logic [DEPTH*AW-1:0] spec_nxt_mem_unused;
  logic [PW-1:0]       spec_nxt_tp_unused;
  logic [PW:0]         spec_nxt_cnt_unused;
  logic [AW-1:0]       cmt_top_unused;
  logic [PW:0]         cmt_cnt_unused;

  assign f_op_s = decode_op(f_icode_i);
  assign w_op_s = decode_op(W_icode_i);

  // Fetch-side decode; a flush drops the wrong-path fetch op and restores.
  always_comb begin
    spec_push_s = 1'b0;
    spec_pop_s  = 1'b0;
    spec_load_s = 1'b0;
    if (flush_i) begin
      spec_load_s = 1'b1;
    end else if (f_fire_i) begin
      case (f_op_s)
        OP_PUSH: spec_push_s = 1'b1;
        OP_POP:  spec_pop_s  = 1'b1;
        default: spec_push_s = 1'b0;
      endcase
    end else begin
      spec_load_s = 1'b0;
    end
  end

  // Write-back decode; the committed stack ignores flushes.
  always_comb begin
    cmt_push_s = 1'b0;
    cmt_pop_s  = 1'b0;
    if (w_commit_i) begin
      case (w_op_s)
        OP_PUSH: cmt_push_s = 1'b1;
        OP_POP:  cmt_pop_s  = 1'b1;
        default: cmt_push_s = 1'b0;
      endcase
    end else begin
      cmt_push_s = 1'b0;
    end
  end

  ras_stack_core #(.DEPTH(DEPTH), .AW(AW)) u_cmt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (cmt_push_s),
    .pop_i       (cmt_pop_s),
    .load_i      (1'b0),
    .push_data_i (W_retaddr_i),
    .load_mem_i  ({(DEPTH*AW){1'b0}}),
    .load_tp_i   ({PW{1'b0}}),
    .load_cnt_i  ({(PW+1){1'b0}}),
    .nxt_mem_o   (cmt_nxt_mem_s),
    .nxt_tp_o    (cmt_nxt_tp_s),
    .nxt_cnt_o   (cmt_nxt_cnt_s),
    .top_o       (cmt_top_unused),
    .cnt_o       (cmt_cnt_unused)
  );

  ras_stack_core #(.DEPTH(DEPTH), .AW(AW)) u_spec (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (spec_push_s),
    .pop_i       (spec_pop_s),
    .load_i      (spec_load_s),
    .push_data_i (f_valP_i),
    .load_mem_i  (cmt_nxt_mem_s),
    .load_tp_i   (cmt_nxt_tp_s),
    .load_cnt_i  (cmt_nxt_cnt_s),
    .nxt_mem_o   (spec_nxt_mem_unused),
    .nxt_tp_o    (spec_nxt_tp_unused),
    .nxt_cnt_o   (spec_nxt_cnt_unused),
    .top_o       (f_predRet_o),
    .cnt_o       (spec_cnt_s)
  );

  assign spec_count_o      = spec_cnt_s;
  assign f_predRet_valid_o = (spec_cnt_s != '0);

endmodule
